// File: rtl/axis_reg_pkg.sv
// Shared constants and helpers for the AXI4-Stream register slice.
//   MODE_*         : slice operating modes
//   payload_width  : width of the packed {tlast, tuser, tkeep, tdata} word
package axis_reg_pkg;

    localparam int unsigned MODE_BYPASS = 0;
    localparam int unsigned MODE_FWD    = 1;
    localparam int unsigned MODE_SKID   = 2;

    function automatic int unsigned payload_width(input int unsigned data_width,
                                                  input int unsigned user_width);
        return data_width + data_width / 8 + user_width + 1;
    endfunction

endpackage

// File: rtl/axis_reg_slice_if.sv
// AXI4-Stream bundle used on both sides of the register slice.
//   master : drives tdata/tkeep/tuser/tlast/tvalid, receives tready
//   slave  : receives tdata/tkeep/tuser/tlast/tvalid, drives tready
interface axis_reg_slice_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_reg_stage.sv
// One register-slice stage operating on the packed payload word.
//   clk, resetn           : clock, async active-low reset
//   s_vld/s_data/s_rdy    : upstream handshake and payload
//   m_vld/m_data/m_rdy    : downstream handshake and payload
// MODE_FWD  : single register, ready derived combinationally from downstream.
// MODE_SKID : main + skid register, ready is a flop (no path from m_rdy).
module axis_reg_stage
    import axis_reg_pkg::*;
#(
    parameter int unsigned MODE = MODE_SKID,
    parameter int unsigned PW   = 38
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_vld,
    input  logic [PW-1:0] s_data,
    output logic          s_rdy,
    output logic          m_vld,
    output logic [PW-1:0] m_data,
    input  logic          m_rdy
);

    generate
        if (MODE == MODE_SKID) begin : g_skid
            logic          mv_q, mv_d;
            logic          sv_q, sv_d;
            logic          rdy_q, rdy_d;
            logic [PW-1:0] w_q, w_d;
            logic [PW-1:0] sw_q, sw_d;
            logic          accept;
            logic          drain;

            // Next-state for main/skid registers; ready is the registered !sv
            always_comb begin
                mv_d   = mv_q;
                sv_d   = sv_q;
                w_d    = w_q;
                sw_d   = sw_q;
                accept = s_vld & rdy_q;
                drain  = mv_q & m_rdy;

                if (drain) begin
                    if (sv_q) begin
                        w_d  = sw_q;
                        sv_d = 1'b0;
                    end else begin
                        mv_d = 1'b0;
                    end
                end

                // accept implies sv_q=0, so a drain here never competes with a skid refill
                if (accept) begin
                    if (!mv_q || m_rdy) begin
                        w_d  = s_data;
                        mv_d = 1'b1;
                    end else begin
                        sw_d = s_data;
                        sv_d = 1'b1;
                    end
                end

                rdy_d = !sv_d;
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    mv_q  <= 1'b0;
                    sv_q  <= 1'b0;
                    rdy_q <= 1'b0;
                    w_q   <= '0;
                    sw_q  <= '0;
                end else begin
                    mv_q  <= mv_d;
                    sv_q  <= sv_d;
                    rdy_q <= rdy_d;
                    w_q   <= w_d;
                    sw_q  <= sw_d;
                end
            end

            assign s_rdy  = rdy_q;
            assign m_vld  = mv_q;
            assign m_data = w_q;
        end else begin : g_fwd
            logic          en_q;
            logic          vld_q;
            logic [PW-1:0] w_q;
            logic          rdy;

            // en_q holds ready low until the first edge after reset release
            assign rdy = en_q & (!vld_q | m_rdy);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    en_q  <= 1'b0;
                    vld_q <= 1'b0;
                    w_q   <= '0;
                end else begin
                    en_q <= 1'b1;
                    if (rdy) begin
                        vld_q <= s_vld;
                        if (s_vld) begin
                            w_q <= s_data;
                        end
                    end
                end
            end

            assign s_rdy  = rdy;
            assign m_vld  = vld_q;
            assign m_data = w_q;
        end
    endgenerate

endmodule

// File: rtl/axis_reg_slice.sv
// Parametrised AXI4-Stream register slice (bypass / forward / full skid).
//   clk     : rising-edge clock
//   resetn  : async active-low reset
//   s_axis  : upstream AXIS (slave modport)
//   m_axis  : downstream AXIS (master modport)
// Chains STAGES identical stages on the packed word {tlast, tuser, tkeep, tdata}.
module axis_reg_slice
    import axis_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned MODE       = MODE_SKID,
    parameter int unsigned STAGES     = 1
) (
    input  logic             clk,
    input  logic             resetn,
    axis_reg_slice_if.slave  s_axis,
    axis_reg_slice_if.master m_axis
);

    localparam int unsigned PW = payload_width(DATA_WIDTH, USER_WIDTH);

    generate
        if (MODE == MODE_BYPASS) begin : g_bypass
            assign m_axis.tdata  = s_axis.tdata;
            assign m_axis.tkeep  = s_axis.tkeep;
            assign m_axis.tuser  = s_axis.tuser;
            assign m_axis.tlast  = s_axis.tlast;
            assign m_axis.tvalid = s_axis.tvalid;
            assign s_axis.tready = m_axis.tready;
        end else begin : g_chain
            logic [PW-1:0] chain_data [STAGES+1];
            logic [STAGES:0] chain_vld;
            logic [STAGES:0] chain_rdy;

            assign chain_data[0] = {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};
            assign chain_vld[0]  = s_axis.tvalid;
            assign s_axis.tready = chain_rdy[0];

            for (genvar i = 0; i < STAGES; i++) begin : g_stage
                axis_reg_stage #(
                    .MODE (MODE),
                    .PW   (PW)
                ) u_stage (
                    .clk    (clk),
                    .resetn (resetn),
                    .s_vld  (chain_vld[i]),
                    .s_data (chain_data[i]),
                    .s_rdy  (chain_rdy[i]),
                    .m_vld  (chain_vld[i+1]),
                    .m_data (chain_data[i+1]),
                    .m_rdy  (chain_rdy[i+1])
                );
            end

            assign chain_rdy[STAGES] = m_axis.tready;
            assign m_axis.tvalid     = chain_vld[STAGES];
            assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = chain_data[STAGES];
        end
    endgenerate

endmodule
